// File: rtl/sc_target_responder.sv
// RTL stand-in for the SystemC target on the sc_* request interface: services
// single/burst reads and writes against a local word memory with fixed read latency.
module sc_target_responder #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 40,
   parameter int ID_WIDTH   = 12,
   parameter int MEM_DEPTH  = 1024,
   parameter int RD_LATENCY = 4
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   input  logic                    sc_valid,
   input  logic                    sc_we,
   input  logic [ADDR_WIDTH-1:0]   sc_addr,
   input  logic [ID_WIDTH-1:0]     sc_id,
   input  logic [7:0]              sc_len,
   input  logic [DATA_WIDTH-1:0]   sc_wdata,
   input  logic [DATA_WIDTH/8-1:0] sc_wstrb,
   output logic                    sc_ready,
   output logic                    sc_valid_out,
   output logic                    sc_we_out,
   output logic [ID_WIDTH-1:0]     sc_id_out,
   output logic [DATA_WIDTH-1:0]   sc_rdata,
   output logic                    sc_last,
   output logic                    sc_err
);

   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int OFS    = $clog2(BYTES);
   localparam int IDX_W  = ADDR_WIDTH - OFS;
   localparam int MIDX_W = $clog2(MEM_DEPTH);
   localparam int LAT_W  = $clog2(RD_LATENCY);

   typedef enum logic [2:0] {IDLE, WDATA, WRESP, RWAIT, RDATA} state_t;

   state_t                state_q, state_d;
   logic [8:0]            cnt_q, cnt_d;
   logic [LAT_W-1:0]      wait_q, wait_d;
   logic [IDX_W-1:0]      base_q, base_d;
   logic [7:0]            len_q, len_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic                  err_q, err_d;

   logic                  ready_d, vout_d, we_out_d, last_d, err_out_d;
   logic [ID_WIDTH-1:0]   id_out_d;
   logic [DATA_WIDTH-1:0] rdata_d;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic                  mem_we;
   logic [MIDX_W-1:0]     mem_widx;

   logic [IDX_W-1:0]      req_idx;
   logic [IDX_W:0]        req_end;
   logic                  req_err;
   logic [IDX_W-1:0]      beat_idx;
   logic [DATA_WIDTH-1:0] beat_word;
   logic                  accept;
   logic                  unused_ok;

   assign accept    = sc_valid && sc_ready;
   assign req_idx   = sc_addr[ADDR_WIDTH-1:OFS];
   // One extra bit so index + len cannot wrap before the range compare.
   assign req_end   = {1'b0, req_idx} + (IDX_W+1)'(sc_len);
   assign req_err   = req_end > (IDX_W+1)'(MEM_DEPTH - 1);
   assign beat_idx  = base_q + IDX_W'(cnt_q);
   assign beat_word = mem[beat_idx[MIDX_W-1:0]];
   assign unused_ok = ^{sc_addr[OFS-1:0], beat_idx[IDX_W-1:MIDX_W]};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wait_d    = wait_q;
      base_d    = base_q;
      len_d     = len_q;
      id_d      = id_q;
      err_d     = err_q;
      ready_d   = 1'b0;
      vout_d    = 1'b0;
      we_out_d  = 1'b0;
      id_out_d  = '0;
      rdata_d   = '0;
      last_d    = 1'b0;
      err_out_d = 1'b0;
      mem_we    = 1'b0;
      mem_widx  = beat_idx[MIDX_W-1:0];

      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (accept) begin
               id_d   = sc_id;
               len_d  = sc_len;
               err_d  = req_err;
               base_d = req_idx;
               cnt_d  = '0;
               wait_d = '0;
               if (sc_we) begin
                  mem_we   = !req_err;
                  mem_widx = req_idx[MIDX_W-1:0];
                  if (sc_len == 8'd0) begin
                     state_d   = WRESP;
                     ready_d   = 1'b0;
                     vout_d    = 1'b1;
                     we_out_d  = 1'b1;
                     id_out_d  = sc_id;
                     last_d    = 1'b1;
                     err_out_d = req_err;
                  end else begin
                     state_d = WDATA;
                     cnt_d   = 9'd1;
                  end
               end else begin
                  state_d = RWAIT;
                  ready_d = 1'b0;
               end
            end
         end
         WDATA: begin
            ready_d = 1'b1;
            if (accept) begin
               mem_we = !err_q;
               cnt_d  = cnt_q + 9'd1;
               if (cnt_q[7:0] == len_q) begin
                  state_d   = WRESP;
                  ready_d   = 1'b0;
                  vout_d    = 1'b1;
                  we_out_d  = 1'b1;
                  id_out_d  = id_q;
                  last_d    = 1'b1;
                  err_out_d = err_q;
               end
            end
         end
         WRESP: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
         RWAIT: begin
            wait_d = wait_q + 1'b1;
            // Beat 0 is registered on the RD_LATENCY-th edge after accept.
            if (wait_q == LAT_W'(RD_LATENCY - 1)) begin
               state_d   = RDATA;
               vout_d    = 1'b1;
               id_out_d  = id_q;
               rdata_d   = err_q ? '0 : beat_word;
               last_d    = (cnt_q[7:0] == len_q);
               err_out_d = err_q;
               cnt_d     = cnt_q + 9'd1;
            end
         end
         RDATA: begin
            if (cnt_q > {1'b0, len_q}) begin
               state_d = IDLE;
               ready_d = 1'b1;
            end else begin
               vout_d    = 1'b1;
               id_out_d  = id_q;
               rdata_d   = err_q ? '0 : beat_word;
               last_d    = (cnt_q[7:0] == len_q);
               err_out_d = err_q;
               cnt_d     = cnt_q + 9'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         wait_q       <= '0;
         sc_ready     <= 1'b0;
         sc_valid_out <= 1'b0;
         sc_we_out    <= 1'b0;
         sc_id_out    <= '0;
         sc_rdata     <= '0;
         sc_last      <= 1'b0;
         sc_err       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wait_q       <= wait_d;
         sc_ready     <= ready_d;
         sc_valid_out <= vout_d;
         sc_we_out    <= we_out_d;
         sc_id_out    <= id_out_d;
         sc_rdata     <= rdata_d;
         sc_last      <= last_d;
         sc_err       <= err_out_d;
      end
   end

   // Transaction context is only consulted after an accept loads it.
   always_ff @(posedge sys_clk) begin
      base_q <= base_d;
      len_q  <= len_d;
      id_q   <= id_d;
      err_q  <= err_d;
   end

   always_ff @(posedge sys_clk) begin
      if (mem_we) begin
         for (int b = 0; b < BYTES; b++) begin
            if (sc_wstrb[b]) mem[mem_widx][b*8 +: 8] <= sc_wdata[b*8 +: 8];
         end
      end
   end

endmodule

// File: doc/sc_target_responder.md
Name: sc_target_responder

Overview:
RTL stand-in for the SystemC target at the far end of the sc_* request interface. It accepts single and burst read/write requests from the sc_* initiator, services them against a local word-addressed memory with configurable read latency, and returns write acknowledges and read data beats on the sc_* response signals. Used in RTL-only regressions in place of the DPI-C/SystemC model.

Parameters:
DATA_WIDTH, 64, data bus width in bits; byte lanes = DATA_WIDTH/8; power of 2, >=16
ADDR_WIDTH, 40, byte address width
ID_WIDTH, 12, transaction ID width
MEM_DEPTH, 1024, memory depth in DATA_WIDTH words; power of 2
RD_LATENCY, 4, cycles from read accept edge to first data beat; >=2

Ports:
sys_clk  in  1  clock; all state updates on rising edge
sys_rst_n  in  1  asynchronous, active-low reset
sc_valid  in  1  request/write-beat valid
sc_we  in  1  1 = write, 0 = read; sampled at request accept
sc_addr  in  ADDR_WIDTH  byte address of beat 0; low log2(DATA_WIDTH/8) bits ignored
sc_id  in  ID_WIDTH  request ID
sc_len  in  8  beats minus 1 (0..255)
sc_wdata  in  DATA_WIDTH  write data, one beat per accepted cycle
sc_wstrb  in  DATA_WIDTH/8  byte enables for sc_wdata
sc_ready  out  1  request/beat accepted when sc_valid && sc_ready
sc_valid_out  out  1  response valid; consumer always accepts
sc_we_out  out  1  response kind: 1 = write ack, 0 = read data
sc_id_out  out  ID_WIDTH  echoed request ID
sc_rdata  out  DATA_WIDTH  read data; 0 on write acks and errored reads
sc_last  out  1  final response beat
sc_err  out  1  out-of-range request

Behaviour:
- All outputs registered. Reset values: all outputs 0. While sys_rst_n is low, state = IDLE and the beat counter = 0. sc_ready rises on the first rising edge after release.
- States: IDLE, WDATA, WRESP, RWAIT, RDATA.
- sc_ready is 1 only in IDLE and WDATA.
- Word index = sc_addr >> log2(DATA_WIDTH/8). Beat n accesses index + n, with no wrap.
- Error rule: err = (index + sc_len > MEM_DEPTH-1), computed at accept and held for the whole transaction.
  - Errored writes change no memory.
  - Errored reads return rdata 0 for every beat.
- IDLE, accept with sc_we=1:
  - Beat 0 is written on the accept edge; latch id, len, err.
  - len==0 -> WRESP; otherwise -> WDATA with counter = 1.
- WDATA: each sc_valid&&sc_ready cycle writes beat[counter] and increments the counter. sc_valid gaps are allowed. sc_addr/sc_id/sc_len/sc_we are ignored in this state. After beat len is written -> WRESP.
- WRESP: exactly one cycle with sc_valid_out=1, sc_we_out=1, sc_last=1, sc_id_out=latched id, sc_err=err, then -> IDLE. The ack appears in the cycle after the final beat is accepted.
- Write strobes: only bytes with wstrb[i]=1 are updated; a strobe of all zeros writes nothing.
- IDLE, accept with sc_we=0: latch id, len, err -> RWAIT.
  - Beat 0 is output (sc_valid_out=1) exactly RD_LATENCY cycles after the accept edge.
  - RDATA then emits len+1 consecutive beats with no bubbles; sc_last=1 only on beat len; then -> IDLE.
- Memory contents are unaffected by reset and are undefined until written.
- Back-to-back: a new request can be accepted in the first IDLE cycle after WRESP or the final RDATA beat. Requests presented outside IDLE/WDATA are held off (sc_ready=0).
- Reset mid-operation: outputs go to 0 immediately (asynchronously) and the FSM returns to IDLE. Write beats already committed remain in memory. No partial ack or remaining read beats are issued.

Test Plan:
1. Write 0x40, id 0x5A, len 0, wdata 0x1122334455667788, wstrb 0xFF -> one ack cycle after accept: we_out=1, id_out=0x5A, last=1, err=0. Then read 0x40 len 0 -> rdata 0x1122334455667788 exactly 4 cycles after accept, last=1.
2. After test 1, write 0x40 wdata all-ones, wstrb 0x0F -> read 0x40 returns 0x11223344FFFFFFFF.
3. Burst write 0x100, len 3, data 1,2,3,4, with a 2-cycle sc_valid gap after beat 1 -> single ack after beat 4. Read 0x100 len 3 -> 4 consecutive beats 1,2,3,4; sc_last only on beat 4.
4. Read 0x2000, len 0 -> rdata 0, err=1. Write 0x1FF8, len 1 -> ack with err=1; a subsequent read of 0x1FF8 returns the prior contents.
5. Hold sc_valid high through a read len 2 -> sc_ready=0 from accept to final beat; the next request is accepted in the cycle after the last beat.
6. Assert sys_rst_n low after 2 beats of a read len 7 -> sc_valid_out=0 immediately, sc_ready=0 during reset and 1 one edge after release. A new write/read to 0x40 then completes per test 1 timing.
